// File: rtl/up_pkg.sv
//==============================================================================
// Module      : up_pkg
// Description : Shared microprocessor types: PC op codes and default address width.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package up_pkg;

    localparam int UP_ADDR_W = 12;

    typedef enum logic [1:0] {
        PC_OP_INC  = 2'd0,
        PC_OP_LOAD = 2'd1,
        PC_OP_CALL = 2'd2,
        PC_OP_RET  = 2'd3
    } pc_op_e;

endpackage

`default_nettype wire

// File: rtl/pc_return_stack.sv
//==============================================================================
// Module      : pc_return_stack
// Description : Parametrised LIFO of return addresses with push/pop and full/empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_return_stack #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    // Low bits of (count-1) depend only on low bits of count, so no wide pointer is needed.
    assign wr_idx   = count_q[IDX_W-1:0];
    assign rd_idx   = wr_idx - IDX_ONE;
    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign top_data = mem_q[rd_idx];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is intentionally left unreset; entries at or above count are stale.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_stack_unit.sv
//==============================================================================
// Module      : pc_stack_unit
// Description : Fetch-stage program counter with hardware return stack and sticky errors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_stack_unit
    import up_pkg::*;
#(
    parameter int                ADDR_W       = UP_ADDR_W,
    parameter int                STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               load,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               clear_err,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               udf_err
);

    localparam int                DEPTH_W  = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    pc_op_e            op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stk_top;
    logic [DEPTH_W-1:0] stk_count;
    logic              stk_full;
    logic              stk_empty;

    assign pc_plus1 = pc_q + ADDR_ONE;

    always_comb begin
        op = PC_OP_INC;
        if (ret) begin
            op = PC_OP_RET;
        end else if (call) begin
            op = PC_OP_CALL;
        end else if (load) begin
            op = PC_OP_LOAD;
        end
    end

    // A new error in the same cycle as clear_err overrides the clear.
    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = clear_err ? 1'b0 : ovf_q;
        udf_d = clear_err ? 1'b0 : udf_q;
        if (en) begin
            case (op)
                PC_OP_LOAD: pc_d = target;
                PC_OP_CALL: begin
                    if (stk_full) begin
                        pc_d  = pc_plus1;
                        ovf_d = 1'b1;
                    end else begin
                        pc_d = target;
                        push = 1'b1;
                    end
                end
                PC_OP_RET: begin
                    if (stk_empty) begin
                        pc_d  = pc_plus1;
                        udf_d = 1'b1;
                    end else begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end
                end
                default: pc_d = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    pc_return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .CNT_W  (DEPTH_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign pc          = pc_q;
    assign depth       = stk_count;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
    assign ovf_err     = ovf_q;
    assign udf_err     = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
//==============================================================================
// Module      : tb_pc_stack_unit
// Description : Self-checking bench for pc_stack_unit against a queue-based model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_stack_unit;

    localparam int ADDR_W = 12;
    localparam int SDEPTH = 4;
    localparam int MASK   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [ADDR_W-1:0] target = '0;
    logic              clear_err = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        depth;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_err;
    logic              udf_err;

    int errors = 0;
    int checks = 0;

    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_udf;

    always #5 clk = ~clk;

    pc_stack_unit #(
        .ADDR_W       (ADDR_W),
        .STACK_DEPTH  (SDEPTH),
        .RESET_VECTOR ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .clear_err   (clear_err),
        .pc          (pc),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    int'(pc), m_pc);
        check({tag, ".depth"}, int'(depth), m_stk.size());
        check({tag, ".full"},  int'(stack_full), int'(m_stk.size() == SDEPTH));
        check({tag, ".empty"}, int'(stack_empty), int'(m_stk.size() == 0));
        check({tag, ".ovf"},   int'(ovf_err), int'(m_ovf));
        check({tag, ".udf"},   int'(udf_err), int'(m_udf));
    endtask

    function automatic void model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit l, bit c, bit r, int t, bit clr);
        bit new_ovf = 1'b0;
        bit new_udf = 1'b0;
        if (e) begin
            if (r) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) & MASK; new_udf = 1'b1; end
            end else if (c) begin
                if (m_stk.size() < SDEPTH) begin
                    m_stk.push_back((m_pc + 1) & MASK);
                    m_pc = t;
                end else begin
                    m_pc = (m_pc + 1) & MASK;
                    new_ovf = 1'b1;
                end
            end else if (l) begin
                m_pc = t;
            end else begin
                m_pc = (m_pc + 1) & MASK;
            end
        end
        m_ovf = new_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = new_udf ? 1'b1 : (clr ? 1'b0 : m_udf);
    endfunction

    task automatic cycle(input bit e, input bit l, input bit c, input bit r,
                         input int t, input bit clr, input string tag);
        @(negedge clk);
        en = e; load = l; call = c; ret = r; target = ADDR_W'(t); clear_err = clr;
        @(posedge clk);
        model_step(e, l, c, r, t, clr);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check({tag, ".pc"},    int'(pc), 0);
        check({tag, ".depth"}, int'(depth), 0);
        check({tag, ".empty"}, int'(stack_empty), 1);
        @(negedge clk);
        en = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; clear_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: free-running increment
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, "inc");
        check("inc.pc5", int'(pc), 5);

        // 2: wrap at the top of the address space
        cycle(1, 1, 0, 0, 'hFFE, 0, "wrap.load");
        cycle(1, 0, 0, 0, 0, 0, "wrap.1");
        cycle(1, 0, 0, 0, 0, 0, "wrap.2");
        check("wrap.pc0", int'(pc), 0);
        cycle(1, 0, 0, 0, 0, 0, "wrap.3");

        // 3: nested call/return
        cycle(1, 1, 0, 0, 'h010, 0, "nest.load");
        cycle(1, 0, 1, 0, 'h200, 0, "nest.call1");
        cycle(1, 0, 1, 0, 'h300, 0, "nest.call2");
        cycle(1, 0, 0, 1, 0, 0, "nest.ret1");
        check("nest.pc201", int'(pc), 'h201);
        cycle(1, 0, 0, 1, 0, 0, "nest.ret2");
        check("nest.pc011", int'(pc), 'h011);

        // 4: overflow, clear, unwind
        for (int i = 0; i < SDEPTH; i++) cycle(1, 0, 1, 0, 'h100 * (i + 1), 0, "ovf.call");
        check("ovf.full", int'(stack_full), 1);
        cycle(1, 0, 1, 0, 'h700, 0, "ovf.extra");
        check("ovf.pc", int'(pc), 'h401);
        cycle(1, 0, 0, 0, 0, 1, "ovf.clear");
        for (int i = 0; i < SDEPTH; i++) cycle(1, 0, 0, 1, 0, 0, "ovf.ret");

        // 5: underflow, then clear colliding with a new underflow
        cycle(1, 1, 0, 0, 'h050, 0, "udf.load");
        cycle(1, 0, 0, 1, 0, 0, "udf.ret");
        check("udf.pc", int'(pc), 'h051);
        cycle(1, 0, 0, 1, 0, 1, "udf.clrret");
        check("udf.sticky", int'(udf_err), 1);
        cycle(1, 0, 0, 0, 0, 1, "udf.clear");

        // 6: priority, hold, async reset
        cycle(1, 0, 1, 0, 'h123, 0, "pri.call");
        cycle(1, 1, 1, 1, 'h456, 0, "pri.all");
        check("pri.pc", int'(pc), 'h051 + 1 + 1 + 1);
        cycle(0, 0, 1, 0, 'h777, 0, "hold.call");
        cycle(0, 0, 0, 1, 0, 0, "hold.ret");
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 'h20 + i, 0, "ar.call");
        check("ar.depth3", int'(depth), 3);
        apply_reset("areset");

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int sel = $urandom_range(0, 99);
            bit e   = ($urandom_range(0, 9) != 0);
            bit r   = (sel < 25);
            bit c   = (sel >= 20 && sel < 55);
            bit l   = (sel >= 50 && sel < 70);
            bit clr = ($urandom_range(0, 9) == 0);
            if (n % 150 == 149) apply_reset("rnd.reset");
            cycle(e, l, c, r, $urandom_range(0, MASK), clr, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
